// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D block-memory arbiter.
// The width defaults are the same ones the caches use.
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 28;
  localparam int ARB_DATA_W = 128;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-requester pick between the I and D clients. This block is purely combinational.
// pick_d = 1 means the D client wins.
module mem_arbiter_rr2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic pick_d
);

  // On a tie, round-robin hands the grant to whichever client was not served last.
  always_comb begin
    pick_d = 1'b0;
    if (req_d && !req_i) begin
      pick_d = 1'b1;
    end else if (req_d && req_i) begin
      pick_d = (FIXED_PRIO != 0) ? 1'b1 : ~last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one slow block memory between the I-cache and the D-cache.
// It serves one registered transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state, state_nxt;
  logic              gnt_d, op_wr, last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_i, req_d, pick_d, grant;

  assign req_i = i_mem_read | i_mem_write;
  assign req_d = d_mem_read | d_mem_write;
  assign grant = (state == ARB_IDLE) && (req_i || req_d);

  mem_arbiter_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req_i  (req_i),
    .req_d  (req_d),
    .last_d (last_d),
    .pick_d (pick_d)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) state <= ARB_IDLE;
    else            state <= state_nxt;
  end

  // After a completion the arbiter always passes through IDLE, so the client can change its request first.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (req_i || req_d) state_nxt = ARB_BUSY;
      ARB_BUSY: if (mem_ready)      state_nxt = ARB_IDLE;
      default:                      state_nxt = ARB_IDLE;
    endcase
  end

  // The winner's request is captured at grant, so its later changes do not reach the memory.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      gnt_d   <= 1'b0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_d  <= 1'b1;
    end else if (grant) begin
      gnt_d   <= pick_d;
      op_wr   <= pick_d ? d_mem_write : i_mem_write;
      addr_q  <= pick_d ? d_mem_addr  : i_mem_addr;
      wdata_q <= pick_d ? d_mem_wdata : i_mem_wdata;
    end else if (state == ARB_BUSY && mem_ready) begin
      last_d  <= gnt_d;
    end
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    if (state == ARB_BUSY) begin
      mem_read    = ~op_wr;
      mem_write   = op_wr;
      i_mem_ready = mem_ready & ~gnt_d;
      d_mem_ready = mem_ready & gnt_d;
    end
  end

  // Read data is broadcast to both ports. Only the ready pulse tells a client that the data is its own.
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. It has one round-robin instance and one fixed-priority instance.
// The sel signal chooses which instance is live.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam logic [DW-1:0] DEAD_DATA = 128'hDEADBEEF_DEADBEEF_DEADBEEF_00000001;
  localparam logic [DW-1:0] WB_DATA   = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

  logic          clk = 1'b0;
  logic          proc_reset;
  bit            sel;
  logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write, mem_ready;
  logic [AW-1:0] i_mem_addr, d_mem_addr;
  logic [DW-1:0] i_mem_wdata, d_mem_wdata, mem_rdata;

  logic          ir_k [2], iw_k [2], dr_k [2], dw_k [2], mrdy_k [2];
  logic          mread_k [2], mwrite_k [2], irdy_k [2], drdy_k [2];
  logic [AW-1:0] maddr_k [2];
  logic [DW-1:0] mwdata_k [2], irdata_k [2], drdata_k [2];

  logic          mem_read, mem_write, i_mem_ready, d_mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, i_mem_rdata, d_mem_rdata;

  int tests_run = 0;
  int tests_failed = 0;
  bit last_was_d;

  typedef struct {
    int            wait_cyc;
    logic          rd, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            stable;
    int            i_rdy, d_rdy;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          after_strobe;
  } obs_t;

  always #5 clk = ~clk;

  // Only the selected instance sees requests and memory responses. The other instance sits idle.
  assign ir_k[0] = i_mem_read & ~sel;   assign ir_k[1] = i_mem_read & sel;
  assign iw_k[0] = i_mem_write & ~sel;  assign iw_k[1] = i_mem_write & sel;
  assign dr_k[0] = d_mem_read & ~sel;   assign dr_k[1] = d_mem_read & sel;
  assign dw_k[0] = d_mem_write & ~sel;  assign dw_k[1] = d_mem_write & sel;
  assign mrdy_k[0] = mem_ready & ~sel;  assign mrdy_k[1] = mem_ready & sel;

  assign mem_read    = mread_k[sel];
  assign mem_write   = mwrite_k[sel];
  assign mem_addr    = maddr_k[sel];
  assign mem_wdata   = mwdata_k[sel];
  assign i_mem_ready = irdy_k[sel];
  assign d_mem_ready = drdy_k[sel];
  assign i_mem_rdata = irdata_k[sel];
  assign d_mem_rdata = drdata_k[sel];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(ir_k[0]), .i_mem_write(iw_k[0]), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_mem_rdata(irdata_k[0]), .i_mem_ready(irdy_k[0]),
    .d_mem_read(dr_k[0]), .d_mem_write(dw_k[0]), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(drdata_k[0]), .d_mem_ready(drdy_k[0]),
    .mem_read(mread_k[0]), .mem_write(mwrite_k[0]), .mem_addr(maddr_k[0]), .mem_wdata(mwdata_k[0]),
    .mem_rdata(mem_rdata), .mem_ready(mrdy_k[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(ir_k[1]), .i_mem_write(iw_k[1]), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_mem_rdata(irdata_k[1]), .i_mem_ready(irdy_k[1]),
    .d_mem_read(dr_k[1]), .d_mem_write(dw_k[1]), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(drdata_k[1]), .d_mem_ready(drdy_k[1]),
    .mem_read(mread_k[1]), .mem_write(mwrite_k[1]), .mem_addr(maddr_k[1]), .mem_wdata(mwdata_k[1]),
    .mem_rdata(mem_rdata), .mem_ready(mrdy_k[1])
  );

  // Reference rule: a lone requester wins. A tie goes to D in fixed mode, or else to whoever was not served last.
  function automatic bit predict_d(input bit ri, input bit rd, input bit fixed);
    if (!ri) return 1'b1;
    if (!rd) return 1'b0;
    if (fixed) return 1'b1;
    return !last_was_d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 0;
  endtask

  task automatic do_reset(input bit mode);
    sel = mode;
    proc_reset = 1'b1;
    clear_reqs();
    mem_ready = 1'b0;
    tick();
    tick();
    proc_reset = 1'b0;
    last_was_d = 1'b1;
  endtask

  // Memory model: waits for a strobe, holds for lat busy cycles, then pulses mem_ready. A client drops its request when it sees its ready.
  task automatic serve(input int lat, input logic [DW-1:0] rdata, input int drop_cyc,
                       input int inj_cyc, input logic [AW-1:0] inj_addr, output obs_t o);
    o.wait_cyc = 0; o.stable = 1'b1; o.i_rdy = 0; o.d_rdy = 0;
    while ((mem_read | mem_write) !== 1'b1 && o.wait_cyc < 8) begin
      tick();
      o.wait_cyc++;
    end
    o.rd = mem_read; o.wr = mem_write; o.addr = mem_addr; o.wdata = mem_wdata;
    for (int c = 1; c < lat; c++) begin
      if (c == drop_cyc) clear_reqs();
      if (c == inj_cyc) begin d_mem_read = 1'b1; d_mem_addr = inj_addr; end
      tick();
      if (mem_read !== o.rd || mem_write !== o.wr || mem_addr !== o.addr || mem_wdata !== o.wdata)
        o.stable = 1'b0;
      o.i_rdy += int'(i_mem_ready); o.d_rdy += int'(d_mem_ready);
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    #1;
    o.i_rdy += int'(i_mem_ready); o.d_rdy += int'(d_mem_ready);
    o.i_rdata = i_mem_rdata; o.d_rdata = d_mem_rdata;
    if (i_mem_ready === 1'b1) begin i_mem_read = 0; i_mem_write = 0; end
    if (d_mem_ready === 1'b1) begin d_mem_read = 0; d_mem_write = 0; end
    tick();
    mem_ready = 1'b0;
    #1;
    o.after_strobe = mem_read | mem_write;
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    sel = 0;
    proc_reset = 1'b1;
    i_mem_read = 1; d_mem_write = 1;
    i_mem_addr = AW'($urandom); d_mem_addr = AW'($urandom);
    d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
    mem_ready = 1'b1; mem_rdata = v;
    tick();
    tick();
    tests_run++;
    if ({mem_read, mem_write} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL reset_strobes: got %b expected 00", {mem_read, mem_write});
    end
    tests_run++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_addr_data: got %h/%h expected 0/0", mem_addr, mem_wdata);
    end
    tests_run++;
    if ({i_mem_ready, d_mem_ready} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 00", {i_mem_ready, d_mem_ready});
    end
    tests_run++;
    if (i_mem_rdata !== v || d_mem_rdata !== v) begin
      tests_failed++; $display("[TB] FAIL reset_rdata_follow: got %h/%h expected %h", i_mem_rdata, d_mem_rdata, v);
    end
    clear_reqs();
    mem_ready = 1'b0;
    proc_reset = 1'b0;
    last_was_d = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    obs_t o;
    do_reset(0);
    i_mem_read = 1; i_mem_addr = 28'h0000010;
    serve(5, DEAD_DATA, 0, 0, '0, o);
    tests_run++;
    if (o.wait_cyc !== 1 || {o.rd, o.wr} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL single_latency: got wait=%0d rd/wr=%b expected 1/10", o.wait_cyc, {o.rd, o.wr});
    end
    tests_run++;
    if (o.addr !== 28'h0000010 || !o.stable) begin
      tests_failed++; $display("[TB] FAIL single_addr: got %h stable=%0d expected 0000010 stable=1", o.addr, o.stable);
    end
    tests_run++;
    if (o.i_rdy !== 1 || o.d_rdy !== 0) begin
      tests_failed++; $display("[TB] FAIL single_ready: got i=%0d d=%0d expected 1 0", o.i_rdy, o.d_rdy);
    end
    tests_run++;
    if (o.i_rdata !== DEAD_DATA || o.after_strobe !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL single_rdata: got %h drop=%b expected %h drop=0", o.i_rdata, o.after_strobe, DEAD_DATA);
    end
    last_was_d = 1'b0;
  endtask

  task automatic test_wb_refill();
    obs_t o;
    logic [DW-1:0] v;
    do_reset(0);
    d_mem_write = 1; d_mem_addr = 28'h00000A3; d_mem_wdata = WB_DATA;
    serve(3, {$urandom, $urandom, $urandom, $urandom}, 0, 0, '0, o);
    tests_run++;
    if ({o.rd, o.wr} !== 2'b01 || o.addr !== 28'h00000A3 || o.wdata !== WB_DATA) begin
      tests_failed++; $display("[TB] FAIL wb_write: got rw=%b addr=%h wdata=%h expected 01 00000a3 %h", {o.rd, o.wr}, o.addr, o.wdata, WB_DATA);
    end
    tests_run++;
    if (o.d_rdy !== 1 || o.i_rdy !== 0 || o.after_strobe !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL wb_ready: got d=%0d i=%0d after=%b expected 1 0 0", o.d_rdy, o.i_rdy, o.after_strobe);
    end
    d_mem_read = 1; d_mem_addr = 28'h0000123;
    v = {$urandom, $urandom, $urandom, $urandom};
    serve(4, v, 0, 0, '0, o);
    tests_run++;
    if (o.wait_cyc !== 1 || {o.rd, o.wr} !== 2'b10 || o.addr !== 28'h0000123) begin
      tests_failed++; $display("[TB] FAIL refill_read: got wait=%0d rw=%b addr=%h expected 1 10 0000123", o.wait_cyc, {o.rd, o.wr}, o.addr);
    end
    tests_run++;
    if (o.d_rdy !== 1 || o.d_rdata !== v) begin
      tests_failed++; $display("[TB] FAIL refill_data: got rdy=%0d data=%h expected 1 %h", o.d_rdy, o.d_rdata, v);
    end
    last_was_d = 1'b1;
  endtask

  task automatic test_simultaneous(input bit mode);
    obs_t o;
    bit   w1, w2, w3;
    do_reset(mode);
    i_mem_read = 1; i_mem_addr = 28'h0000004;
    d_mem_read = 1; d_mem_addr = 28'h0000008;
    w1 = predict_d(1, 1, mode);
    serve(2, {$urandom, $urandom, $urandom, $urandom}, 0, 0, '0, o);
    tests_run++;
    if (o.addr !== (w1 ? 28'h0000008 : 28'h0000004) || o.d_rdy !== int'(w1) || o.i_rdy !== int'(!w1)) begin
      tests_failed++; $display("[TB] FAIL simul%0d_first: got addr=%h i=%0d d=%0d expected winner_d=%0d", mode, o.addr, o.i_rdy, o.d_rdy, w1);
    end
    last_was_d = w1;
    if (w1) d_mem_read = 1; else i_mem_read = 1;
    w2 = predict_d(1, 1, mode);
    serve(3, {$urandom, $urandom, $urandom, $urandom}, 0, 0, '0, o);
    tests_run++;
    if (o.wait_cyc !== 1 || o.addr !== (w2 ? 28'h0000008 : 28'h0000004) || o.d_rdy !== int'(w2) || o.i_rdy !== int'(!w2)) begin
      tests_failed++; $display("[TB] FAIL simul%0d_second: got wait=%0d addr=%h i=%0d d=%0d expected winner_d=%0d", mode, o.wait_cyc, o.addr, o.i_rdy, o.d_rdy, w2);
    end
    last_was_d = w2;
    w3 = !w2;
    serve(2, {$urandom, $urandom, $urandom, $urandom}, 0, 0, '0, o);
    tests_run++;
    if (o.addr !== (w3 ? 28'h0000008 : 28'h0000004) || o.d_rdy !== int'(w3) || o.i_rdy !== int'(!w3)) begin
      tests_failed++; $display("[TB] FAIL simul%0d_third: got addr=%h i=%0d d=%0d expected winner_d=%0d", mode, o.addr, o.i_rdy, o.d_rdy, w3);
    end
    last_was_d = w3;
  endtask

  task automatic test_mid_arrival();
    obs_t o;
    logic [AW-1:0] a_i, a_d;
    a_i = AW'($urandom); a_d = AW'($urandom);
    do_reset(0);
    i_mem_read = 1; i_mem_addr = a_i;
    serve(6, {$urandom, $urandom, $urandom, $urandom}, 0, 2, a_d, o);
    tests_run++;
    if (o.addr !== a_i || !o.stable || o.i_rdy !== 1 || o.d_rdy !== 0) begin
      tests_failed++; $display("[TB] FAIL mid_hold: got addr=%h stable=%0d i=%0d d=%0d expected %h 1 1 0", o.addr, o.stable, o.i_rdy, o.d_rdy, a_i);
    end
    serve(3, {$urandom, $urandom, $urandom, $urandom}, 0, 0, '0, o);
    tests_run++;
    if (o.wait_cyc !== 1 || o.addr !== a_d || o.d_rdy !== 1 || o.i_rdy !== 0) begin
      tests_failed++; $display("[TB] FAIL mid_then_d: got wait=%0d addr=%h d=%0d i=%0d expected 1 %h 1 0", o.wait_cyc, o.addr, o.d_rdy, o.i_rdy, a_d);
    end
  endtask

  task automatic test_drop_and_idle_ready();
    obs_t o;
    do_reset(0);
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if ({i_mem_ready, d_mem_ready} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL idle_ready: got %b expected 00", {i_mem_ready, d_mem_ready});
    end
    tick();
    mem_ready = 1'b0;
    tests_run++;
    if ({mem_read, mem_write} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL idle_ready_state: got %b expected 00", {mem_read, mem_write});
    end
    d_mem_read = 1; d_mem_addr = AW'($urandom);
    serve(4, {$urandom, $urandom, $urandom, $urandom}, 1, 0, '0, o);
    tests_run++;
    if (o.d_rdy !== 1 || !o.stable || o.after_strobe !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL drop_complete: got d=%0d stable=%0d after=%b expected 1 1 0", o.d_rdy, o.stable, o.after_strobe);
    end
  endtask

  task automatic test_abort();
    obs_t o;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    do_reset(0);
    i_mem_read = 1; i_mem_addr = AW'($urandom) | 28'h1;
    tick();
    tests_run++;
    if (mem_read !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL abort_started: got %b expected 1", mem_read);
    end
    tick();
    tick();
    proc_reset = 1'b1;
    clear_reqs();
    tick();
    tests_run++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000 || mem_addr !== '0) begin
      tests_failed++; $display("[TB] FAIL abort_idle: got %b addr=%h expected 0000 0", {mem_read, mem_write, i_mem_ready, d_mem_ready}, mem_addr);
    end
    proc_reset = 1'b0;
    last_was_d = 1'b1;
    a = AW'($urandom); w = {$urandom, $urandom, $urandom, $urandom};
    d_mem_write = 1; d_mem_addr = a; d_mem_wdata = w;
    serve(2, {$urandom, $urandom, $urandom, $urandom}, 0, 0, '0, o);
    tests_run++;
    if (o.wait_cyc !== 1 || {o.rd, o.wr} !== 2'b01 || o.addr !== a || o.wdata !== w || o.d_rdy !== 1) begin
      tests_failed++; $display("[TB] FAIL abort_recover: got wait=%0d rw=%b addr=%h d=%0d expected 1 01 %h 1", o.wait_cyc, {o.rd, o.wr}, o.addr, o.d_rdy, a);
    end
  endtask

  task automatic test_random(input bit mode);
    obs_t o;
    bit pend_i, pend_d, wr_i, wr_d, ed, ewr;
    logic [AW-1:0] a_i, a_d, ea;
    logic [DW-1:0] wd_i, wd_d, ew, rd;
    do_reset(mode);
    pend_i = 0; pend_d = 0; wr_i = 0; wr_d = 0;
    a_i = '0; a_d = '0; wd_i = '0; wd_d = '0;
    for (int it = 0; it < 25; it++) begin
      if (!pend_i && $urandom_range(1, 0) == 1) begin
        pend_i = 1; wr_i = 1'($urandom); a_i = AW'($urandom);
        wd_i = {$urandom, $urandom, $urandom, $urandom};
        i_mem_read = !wr_i; i_mem_write = wr_i; i_mem_addr = a_i; i_mem_wdata = wd_i;
      end
      if (!pend_d && $urandom_range(1, 0) == 1) begin
        pend_d = 1; wr_d = 1'($urandom); a_d = AW'($urandom);
        wd_d = {$urandom, $urandom, $urandom, $urandom};
        d_mem_read = !wr_d; d_mem_write = wr_d; d_mem_addr = a_d; d_mem_wdata = wd_d;
      end
      if (!pend_i && !pend_d) begin
        tick();
        continue;
      end
      ed  = predict_d(pend_i, pend_d, mode);
      ewr = ed ? wr_d : wr_i;
      ea  = ed ? a_d : a_i;
      ew  = ed ? wd_d : wd_i;
      rd  = {$urandom, $urandom, $urandom, $urandom};
      serve(int'($urandom_range(4, 1)), rd, 0, 0, '0, o);
      tests_run++;
      if (o.wait_cyc !== 1 || {o.rd, o.wr} !== {!ewr, ewr} || o.addr !== ea || (ewr && o.wdata !== ew)) begin
        tests_failed++; $display("[TB] FAIL rand%0d_req it=%0d: got wait=%0d rw=%b addr=%h expected 1 %b %h", mode, it, o.wait_cyc, {o.rd, o.wr}, o.addr, {!ewr, ewr}, ea);
      end
      tests_run++;
      if (o.i_rdy !== int'(!ed) || o.d_rdy !== int'(ed) || (ed ? o.d_rdata : o.i_rdata) !== rd || !o.stable || o.after_strobe !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL rand%0d_resp it=%0d: got i=%0d d=%0d stable=%0d after=%b expected winner_d=%0d", mode, it, o.i_rdy, o.d_rdy, o.stable, o.after_strobe, ed);
      end
      if (ed) pend_d = 0; else pend_i = 0;
      last_was_d = ed;
    end
  endtask

  initial begin
    proc_reset = 1'b1;
    sel = 0;
    clear_reqs();
    i_mem_addr = '0; d_mem_addr = '0; i_mem_wdata = '0; d_mem_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    last_was_d = 1'b1;
    test_reset();
    test_single_read();
    test_wb_refill();
    test_simultaneous(0);
    test_simultaneous(1);
    test_mid_arrival();
    test_drop_and_idle_ready();
    test_abort();
    test_random(0);
    test_random(1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
